stupidrv_dbus: RTL and testbench

Data-side bus bridge sitting directly downstream of the stupidrv core's data port. Converts the core's single-cycle combinational request (`dmem_valid`/`dmem_addr`/`dmem_wstrb`/`dmem_wdata`) into a registered valid/ready memory transaction. It freezes the core through `stall` until the transaction completes, then returns read data. A watchdog aborts transactions the memory never acknowledges.

---
 rtl/stupidrv_dbus.sv | 136 +++++++++++++
 tb/tb_stupidrv_dbus.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stupidrv_dbus.sv
// Data-side bus bridge: turns the core's combinational data request into a
// registered valid/ready transaction, stalling the core until it completes.
// A watchdog aborts transactions that the memory never acknowledges.
module stupidrv_dbus #(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ABORT_RDATA = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 32;

  // Watchdog fires when the wait counter reaches TIMEOUT-1 with no acknowledge.
  localparam logic             WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? (CNT_W'(TIMEOUT) - CNT_W'(1)) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic               mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
  logic [STRB_W-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  rdata_q,     rdata_d;
  logic               err_q,       err_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  // State and datapath registers; reset drops any in-flight bus request.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic and the combinational core stall.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        stall = dmem_valid;
        if (dmem_valid) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = {dmem_addr[31:2], 2'b00};
          mem_wstrb_d = dmem_wstrb;
          mem_wdata_d = dmem_wdata;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end

      REQ: begin
        stall = 1'b1;
        if (mem_ready) begin
          // Writes return zero so the core never sees stale bus data.
          rdata_d     = (mem_wstrb_q == '0) ? mem_rdata : '0;
          mem_valid_d = 1'b0;
          state_d     = DONE;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          rdata_d     = ABORT_RDATA;
          err_d       = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Core has moved on; always pass through IDLE before a new request.
        stall   = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        err_d       = 1'b0;
      end
    endcase
  end

  assign dmem_rdata = rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_stupidrv_dbus.sv
// Self-checking bench for stupidrv_dbus with a small watchdog limit.
module tb_stupidrv_dbus;

  localparam int unsigned TO    = 4;
  localparam logic [31:0] ABORT = 32'hBAD0_0BAD;

  logic        clock = 1'b0;
  logic        resetn;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  stupidrv_dbus #(.TIMEOUT(TO), .ABORT_RDATA(ABORT)) dut (
    .clock(clock), .resetn(resetn),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .stall(stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "bench hung");
  end

  // Drives one access from IDLE (caller sits 1ns after a rising edge) and
  // reports what was observed; ready_at is the REQ cycle index to acknowledge
  // in, or -1 for never.
  task automatic access(input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input int ready_at,
                        input logic [31:0] rd,
                        output int stall_cnt, output int valid_cnt,
                        output logic stable, output logic [31:0] a0,
                        output logic [3:0] s0, output logic [31:0] d0,
                        output logic [31:0] got_rd, output logic got_err,
                        output logic done);
    stall_cnt = 0; valid_cnt = 0; stable = 1'b1; a0 = '0; s0 = '0; d0 = '0;
    got_rd = '0; got_err = 1'b0; done = 1'b0;
    dmem_valid = 1'b1; dmem_addr = addr; dmem_wstrb = wstrb; dmem_wdata = wdata;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (mem_valid) begin
        if (valid_cnt == 0) begin
          a0 = mem_addr; s0 = mem_wstrb; d0 = mem_wdata;
        end else if (mem_addr !== a0 || mem_wstrb !== s0 || mem_wdata !== d0) begin
          stable = 1'b0;
        end
        mem_ready = (valid_cnt == ready_at);
        mem_rdata = mem_ready ? rd : 32'h5555_AAAA;
        valid_cnt++;
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (stall) begin
        stall_cnt++;
      end else if (cyc > 0) begin
        got_rd = dmem_rdata; got_err = err; done = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    dmem_valid = 1'b0;
    mem_ready  = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; dmem_valid = 1'b0; dmem_addr = '0; dmem_wstrb = '0;
    dmem_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #3;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wstrb_wdata: got %h/%h want 0/0", mem_wstrb, mem_wdata); end
    checks++; if (dmem_rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL reset_rdata_err: got %h/%b want 0/0", dmem_rdata, err); end
    dmem_valid = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follow1: got %b want 1", stall); end
    dmem_valid = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_follow0: got %b want 0", stall); end
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_read_zero_wait();
    int sc, vc; logic st, er, dn; logic [31:0] a, d, r; logic [3:0] s;
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    access(32'h1006, 4'h0, 32'h0, 0, 32'hDEADBEEF, sc, vc, st, a, s, d, r, er, dn);
    e = sb.pop_front();
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL read0_done: got %b want 1", dn); end
    checks++; if (a !== 32'h1004) begin errors++; $display("FAIL read0_addr: got %h want 00001004", a); end
    checks++; if (sc != 2 || vc != 1) begin errors++; $display("FAIL read0_latency: stall=%0d valid=%0d want 2/1", sc, vc); end
    checks++; if (r !== e.rdata || er !== e.err) begin errors++; $display("FAIL read0_data: got %h/%b want %h/%b", r, er, e.rdata, e.err); end
    @(posedge clock); #1;
  endtask

  task automatic test_write_wait();
    int sc, vc; logic st, er, dn; logic [31:0] a, d, r; logic [3:0] s;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    access(32'h2003, 4'b0011, 32'h12345678, 3, 32'hFFFF_FFFF, sc, vc, st, a, s, d, r, er, dn);
    e = sb.pop_front();
    checks++; if (vc != 4 || st !== 1'b1) begin errors++; $display("FAIL write_valid: cycles=%0d stable=%b want 4/1", vc, st); end
    checks++; if (a !== 32'h2000 || s !== 4'b0011 || d !== 32'h12345678) begin errors++; $display("FAIL write_bus: got %h/%h/%h want 00002000/3/12345678", a, s, d); end
    checks++; if (sc != 5 || dn !== 1'b1) begin errors++; $display("FAIL write_stall: stall=%0d done=%b want 5/1", sc, dn); end
    checks++; if (r !== e.rdata || er !== e.err) begin errors++; $display("FAIL write_rdata: got %h/%b want %h/%b", r, er, e.rdata, e.err); end
    @(posedge clock); #1;
  endtask

  task automatic test_timeout();
    int sc, vc; logic st, er, dn; logic [31:0] a, d, r; logic [3:0] s;
    sb.push_back('{rdata: ABORT, err: 1'b1});
    access(32'h3010, 4'h0, 32'h0, -1, 32'h0, sc, vc, st, a, s, d, r, er, dn);
    e = sb.pop_front();
    checks++; if (vc != int'(TO) || sc != int'(TO) + 1) begin errors++; $display("FAIL timeout_len: valid=%0d stall=%0d want %0d/%0d", vc, sc, TO, TO + 1); end
    checks++; if (r !== e.rdata || er !== e.err) begin errors++; $display("FAIL timeout_abort: got %h/%b want %h/%b", r, er, e.rdata, e.err); end
    @(posedge clock); #1;
    checks++; if (err !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL timeout_err_pulse: err=%b mem_valid=%b want 0/0", err, mem_valid); end
    checks++; if (dmem_rdata !== ABORT) begin errors++; $display("FAIL timeout_rdata_hold: got %h want %h", dmem_rdata, ABORT); end
    // Acknowledge on the last permitted cycle counts as success.
    sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
    access(32'h3020, 4'h0, 32'h0, int'(TO) - 1, 32'hCAFEF00D, sc, vc, st, a, s, d, r, er, dn);
    e = sb.pop_front();
    checks++; if (r !== e.rdata || er !== e.err || vc != int'(TO)) begin errors++; $display("FAIL timeout_edge: got %h/%b valid=%0d want %h/%b/%0d", r, er, vc, e.rdata, e.err, TO); end
    @(posedge clock); #1;
  endtask

  task automatic test_drop_in_req();
    dmem_valid = 1'b1; dmem_addr = 32'h4000; dmem_wstrb = 4'h0; dmem_wdata = '0;
    @(posedge clock); #1;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL drop_req_start: mem_valid=%b want 1", mem_valid); end
    dmem_valid = 1'b0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL drop_req_stall: got %b want 1", stall); end
    @(posedge clock); #1;
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h4000) begin errors++; $display("FAIL drop_req_hold: %b/%h want 1/00004000", mem_valid, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clock); #1;
    mem_ready = 1'b0;
    checks++; if (stall !== 1'b0 || mem_valid !== 1'b0 || dmem_rdata !== 32'h1111_2222) begin errors++; $display("FAIL drop_req_done: stall=%b valid=%b rdata=%h want 0/0/11112222", stall, mem_valid, dmem_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++; if (mem_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL drop_req_idle%0d: valid=%b stall=%b want 0/0", i, mem_valid, stall); end
    end
  endtask

  task automatic test_async_reset();
    int sc, vc; logic st, er, dn; logic [31:0] a, d, r; logic [3:0] s;
    dmem_valid = 1'b1; dmem_addr = 32'h5000; dmem_wstrb = 4'h0;
    @(posedge clock); #1;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: mem_valid=%b want 1", mem_valid); end
    #2; resetn = 1'b0; #1;
    checks++; if (mem_valid !== 1'b0 || err !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL areset_drop: valid=%b err=%b addr=%h want 0/0/0", mem_valid, err, mem_addr); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL areset_idle_stall: got %b want 1", stall); end
    dmem_valid = 1'b0;
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    access(32'h500C, 4'h0, 32'h0, 0, 32'h0BAD_F00D, sc, vc, st, a, s, d, r, er, dn);
    e = sb.pop_front();
    checks++; if (sc != 2 || vc != 1 || a !== 32'h500C) begin errors++; $display("FAIL areset_after: stall=%0d valid=%0d addr=%h want 2/1/0000500c", sc, vc, a); end
    checks++; if (r !== e.rdata || er !== e.err) begin errors++; $display("FAIL areset_after_data: got %h/%b want %h/%b", r, er, e.rdata, e.err); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    sb.push_back('{rdata: 32'hA1A1_0001, err: 1'b0});
    sb.push_back('{rdata: 32'hA2A2_0002, err: 1'b0});
    dmem_valid = 1'b1; dmem_addr = 32'h6000; dmem_wstrb = 4'h0;
    @(posedge clock); #1;
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h6000) begin errors++; $display("FAIL b2b_first_req: %b/%h want 1/00006000", mem_valid, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'hA1A1_0001;
    @(posedge clock); #1;
    mem_ready = 1'b0; dmem_addr = 32'h6008; #1;
    e = sb.pop_front();
    checks++; if (stall !== 1'b0 || dmem_rdata !== e.rdata || err !== e.err) begin errors++; $display("FAIL b2b_first_done: stall=%b rdata=%h err=%b want 0/%h/%b", stall, dmem_rdata, err, e.rdata, e.err); end
    @(posedge clock); #1;
    // Stray acknowledge while idle must be ignored.
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777; #1;
    checks++; if (mem_valid !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_gap: valid=%b stall=%b want 0/1", mem_valid, stall); end
    @(posedge clock); #1;
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h6008) begin errors++; $display("FAIL b2b_second_req: %b/%h want 1/00006008", mem_valid, mem_addr); end
    mem_rdata = 32'hA2A2_0002;
    @(posedge clock); #1;
    mem_ready = 1'b0; dmem_valid = 1'b0; #1;
    e = sb.pop_front();
    checks++; if (stall !== 1'b0 || dmem_rdata !== e.rdata || err !== e.err) begin errors++; $display("FAIL b2b_second_done: stall=%b rdata=%h err=%b want 0/%h/%b", stall, dmem_rdata, err, e.rdata, e.err); end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_drop_in_req();
    test_async_reset();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
